pipe_cla_addsub: RTL
====================

PIPE_CLA_ADDSUB -- requirements
Module: pipe_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 64: operand and result width in bits.
REQ-002 Parameter GROUP, default 4: bits per lookahead group.
REQ-003 Parameter STAGES, default 2: pipeline register stages; WIDTH SHALL be divisible by STAGES*GROUP, else elaboration error.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  beat accepted when in_valid && in_ready at rising edge.
REQ-008 op1  input  WIDTH  first operand.
REQ-009 op2  input  WIDTH  second operand.
REQ-010 sub  input  1  0 = op1+op2+cin; 1 = op1-op2 (op2 inverted, carry-in forced 1, cin ignored).
REQ-011 cin  input  1  carry-in for add mode.
REQ-012 out_valid  output  1  result beat present.
REQ-013 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-014 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-015 crout  output  1  carry out of MSB (sub: 1 = no borrow).
REQ-016 ovf  output  1  two's-complement signed overflow.

Function
REQ-017 Carry chain SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k computed in stage k using GROUP-bit lookahead groups plus a group-level lookahead; inter-slice carry registered.
REQ-018 Upper-slice operands SHALL be delayed alongside the carry; completed lower-slice sum bits SHALL be carried forward, so each beat's result is exact.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when out_ready held 1.
REQ-020 Throughput SHALL be one beat per cycle when out_ready held 1.
REQ-021 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en combinationally.
REQ-022 When en = 0, all stage registers including valid bits SHALL hold; sum/crout/ovf SHALL stay stable while out_valid && !out_ready.
REQ-023 Bubbles (in_valid = 0 while en = 1) SHALL propagate as valid = 0 stages; no beat duplicated or dropped.
REQ-024 Simultaneous accept at input and drain at output in the same cycle SHALL both occur.
REQ-025 ovf SHALL be carry-into-MSB XOR carry-out-of-MSB of the effective addition.
REQ-026 Mode bits (sub, cin) SHALL be sampled at acceptance and travel with the beat.

Reset
REQ-027 reset low SHALL immediately clear every stage valid bit, out_valid, sum, crout, ovf to 0, independent of clock.
REQ-028 Beats in flight at reset SHALL be discarded; no output beat appears for them after release.
REQ-029 in_ready SHALL be 1 during and after reset (pipeline empty).
REQ-030 First beat accepted on the first rising edge with reset high SHALL complete normally.

Structure
REQ-031 Shared package cla_pkg SHALL hold default WIDTH/GROUP/STAGES constants and the propagate/generate pair typedef.
REQ-032 One sub-module cla_group SHALL implement a GROUP-bit lookahead cell (inputs a, b, c_in; outputs s, group P, group G); pipe_cla_addsub instantiates WIDTH/GROUP of them.

Verification
REQ-033 Defaults, out_ready=1, op1=64'hf20f_ffff_ffff_ffff, op2=64'hffff_ffff_ffff_ff50, sub=0, cin=0 -> two cycles later sum=64'hf20f_ffff_ffff_ff4f, crout=1, ovf=0.
REQ-034 op1=0, op2=1, sub=1 -> sum=64'hffff_ffff_ffff_ffff, crout=0, ovf=0; op1=5, op2=5, sub=1 -> sum=0, crout=1.
REQ-035 op1=64'h7fff_ffff_ffff_ffff, op2=0, cin=1 -> sum=64'h8000_0000_0000_0000, ovf=1, crout=0.
REQ-036 Stream 100 random beats with random in_valid gaps and out_ready toggling -> outputs match reference model in order, none lost/duplicated, outputs stable while stalled.
REQ-037 Assert reset low with two beats in flight -> out_valid=0, sum=0 immediately; after release no stale beat emerges, in_ready=1.
REQ-038 Repeat REQ-033/036 with WIDTH=32, GROUP=8, STAGES=4 -> latency 4, results correct modulo 2^32.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and propagate/generate helpers for the pipelined
// carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int unsigned CLA_WIDTH  = 64;
    localparam int unsigned CLA_GROUP  = 4;
    localparam int unsigned CLA_STAGES = 2;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    // Combine a more-significant span (hi) with a less-significant span (lo).
    function automatic pg_t pg_merge(input pg_t hi, input pg_t lo);
        pg_t r;
        r.p = hi.p & lo.p;
        r.g = hi.g | (hi.p & lo.g);
        return r;
    endfunction

    function automatic logic pg_carry(input pg_t span, input logic c_in);
        return span.g | (span.p & c_in);
    endfunction

endpackage

// File: rtl/cla_group.sv
// GROUP-bit carry-lookahead cell: sum bits plus group propagate/generate.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             c_in,
    output logic [GROUP-1:0] s,
    output logic             p,
    output logic             g
);

    pg_t [GROUP-1:0] bit_pg_s;
    pg_t             span_s;
    pg_t             pfx_s;

    // Per-bit propagate/generate terms
    always_comb begin
        for (int i = 0; i < GROUP; i++) begin
            bit_pg_s[i].p = a[i] ^ b[i];
            bit_pg_s[i].g = a[i] & b[i];
        end
    end

    // Group P/G kept apart from c_in so the slice-level lookahead never loops back
    always_comb begin
        span_s = '{p: 1'b1, g: 1'b0};
        for (int i = 0; i < GROUP; i++) begin
            span_s = pg_merge(bit_pg_s[i], span_s);
        end
        p = span_s.p;
        g = span_s.g;
    end

    // Sum bits from prefix carries, each derived directly from c_in
    always_comb begin
        pfx_s = '{p: 1'b1, g: 1'b0};
        s     = '0;
        for (int i = 0; i < GROUP; i++) begin
            s[i]  = bit_pg_s[i].p ^ pg_carry(pfx_s, c_in);
            pfx_s = pg_merge(bit_pg_s[i], pfx_s);
        end
    end

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: slice k of the carry chain is resolved in stage k,
// with a single global advance enable for backpressure.
module pipe_cla_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = CLA_WIDTH,
    parameter int unsigned GROUP  = CLA_GROUP,
    parameter int unsigned STAGES = CLA_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             crout,
    output logic             ovf
);

    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned NGRP  = WIDTH / GROUP;
    localparam int unsigned GPS   = SLICE / GROUP;

    if ((WIDTH % (STAGES * GROUP)) != 0) begin : g_cfg_err
        $error("pipe_cla_addsub: WIDTH must be divisible by STAGES*GROUP");
    end

    logic             en_s;
    logic [WIDTH-1:0] a_s [STAGES];
    logic [WIDTH-1:0] b_s [STAGES];
    logic [STAGES-1:0] c_s;
    logic [NGRP-1:0]  gp_s;
    logic [NGRP-1:0]  gg_s;
    logic [NGRP-1:0]  gc_s;
    logic [WIDTH-1:0] gsum_s;
    logic [STAGES-1:0] slice_co_s;
    logic             msb_c_s;
    pg_t              span_s;
    pg_t              grp_s;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] b_d   [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             crout_q;
    logic             crout_d;
    logic             ovf_q;
    logic             ovf_d;

    // Operands and slice carry-in seen by each stage; subtraction is folded in at acceptance
    always_comb begin
        a_s[0] = op1;
        b_s[0] = op2 ^ {WIDTH{sub}};
        c_s    = '0;
        c_s[0] = sub | cin;
        for (int k = 1; k < STAGES; k++) begin
            a_s[k] = a_q[k-1];
            b_s[k] = b_q[k-1];
            c_s[k] = carry_q[k-1];
        end
    end

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        localparam int unsigned K = j / GPS;
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a    (a_s[K][j*GROUP +: GROUP]),
            .b    (b_s[K][j*GROUP +: GROUP]),
            .c_in (gc_s[j]),
            .s    (gsum_s[j*GROUP +: GROUP]),
            .p    (gp_s[j]),
            .g    (gg_s[j])
        );
    end

    // Group-level lookahead inside each slice, seeded from that slice's carry-in
    always_comb begin
        gc_s       = '0;
        slice_co_s = '0;
        span_s     = '{p: 1'b1, g: 1'b0};
        grp_s      = '{p: 1'b0, g: 1'b0};
        for (int k = 0; k < STAGES; k++) begin
            span_s = '{p: 1'b1, g: 1'b0};
            for (int j = 0; j < GPS; j++) begin
                gc_s[k*GPS + j] = pg_carry(span_s, c_s[k]);
                grp_s.p         = gp_s[k*GPS + j];
                grp_s.g         = gg_s[k*GPS + j];
                span_s          = pg_merge(grp_s, span_s);
            end
            slice_co_s[k] = pg_carry(span_s, c_s[k]);
        end
    end

    // Carry into the MSB recovered from its sum bit and effective operands
    always_comb begin
        msb_c_s = gsum_s[WIDTH-1] ^ a_s[STAGES-1][WIDTH-1] ^ b_s[STAGES-1][WIDTH-1];
    end

    // Next-state: each stage inherits finished low bits and fills in its own slice
    always_comb begin
        en_s       = ~valid_q[STAGES-1] | out_ready;
        valid_d    = '0;
        valid_d[0] = in_valid;
        sum_d[0]   = '0;
        sum_d[0][SLICE-1:0] = gsum_s[SLICE-1:0];
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            sum_d[k]   = sum_q[k-1];
            sum_d[k][k*SLICE +: SLICE] = gsum_s[k*SLICE +: SLICE];
        end
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]     = a_s[k];
            b_d[k]     = b_s[k];
            carry_d[k] = slice_co_s[k];
        end
        crout_d = slice_co_s[STAGES-1];
        ovf_d   = msb_c_s ^ slice_co_s[STAGES-1];
    end

    // Stage registers; everything holds together when the output is stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            crout_q <= 1'b0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                carry_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
            end
        end else if (en_s) begin
            valid_q <= valid_d;
            crout_q <= crout_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                carry_q[k] <= carry_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
            end
        end
    end

    assign in_ready  = en_s;
    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign crout     = crout_q;
    assign ovf       = ovf_q;

endmodule
